// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int ZERO_REG_IDX = 0;
  localparam int XLEN = 32;

  // Address width that stays >= 1 so a single-entry file is legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_wr_sel.sv
// Highest-index write-port selection for one address.
// Shared by storage update and read bypass.
module regfile_wr_sel
  import regfile_pkg::*;
#(
  parameter int BitWidth      = XLEN,
  parameter int NumReg        = 32,
  parameter int NumWritePorts = 2,
  parameter int ZeroReg       = 1,
  localparam int AW           = clog2_min1(NumReg)
) (
  input  logic [NumWritePorts-1:0]               write_en,
  input  logic [NumWritePorts-1:0][AW-1:0]       write_dest,
  input  logic [NumWritePorts-1:0][BitWidth-1:0] write_data,
  input  logic [AW-1:0]                          addr,
  output logic                                   hit,
  output logic [BitWidth-1:0]                    data
);

  localparam logic [AW:0] NREG = (AW+1)'(NumReg);
  localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG_IDX);
  localparam bit HAS_ZERO = (ZeroReg != 0);

  logic ok;

  // Out-of-range and hardwired-zero addresses never take a write.
  assign ok = ({1'b0, addr} < NREG) &&
              !(HAS_ZERO && (addr == ZIDX));

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NumWritePorts; p++) begin
      if (ok && write_en[p] &&
          (write_dest[p] == addr)) begin
        hit  = 1'b1;
        data = write_data[p];
      end
    end
  end

endmodule

// File: rtl/regfile_mpsb.sv
// Multi-port register file with write bypass
// and a per-register busy scoreboard.
module regfile_mpsb
  import regfile_pkg::*;
#(
  parameter int BitWidth      = XLEN,
  parameter int NumReg        = 32,
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 2,
  parameter int ZeroReg       = 1,
  parameter int Bypass        = 1,
  localparam int AW           = clog2_min1(NumReg)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NumReadPorts-1:0][AW-1:0]        read_src,
  output logic [NumReadPorts-1:0][BitWidth-1:0]  read_data,
  output logic [NumReadPorts-1:0]                read_busy,
  input  logic [NumWritePorts-1:0]               write_en,
  input  logic [NumWritePorts-1:0][AW-1:0]       write_dest,
  input  logic [NumWritePorts-1:0][BitWidth-1:0] write_data,
  input  logic                                   issue_en,
  input  logic [AW-1:0]                          issue_dest,
  output logic [NumReg-1:0]                      busy_vec
);

  localparam bit HAS_ZERO = (ZeroReg != 0);
  localparam bit HAS_BYP  = (Bypass != 0);
  localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG_IDX);

  logic [BitWidth-1:0] regs   [NumReg];
  logic [BitWidth-1:0] wr_val [NumReg];
  logic [NumReg-1:0]   wr_hit;
  logic [NumReg-1:0]   set;
  logic [NumReg-1:0]   busy;

  for (genvar i = 0; i < NumReg; i++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(i);

    regfile_wr_sel #(
      .BitWidth      (BitWidth),
      .NumReg        (NumReg),
      .NumWritePorts (NumWritePorts),
      .ZeroReg       (ZeroReg)
    ) u_sel (
      .write_en   (write_en),
      .write_dest (write_dest),
      .write_data (write_data),
      .addr       (IDX),
      .hit        (wr_hit[i]),
      .data       (wr_val[i])
    );

    assign set[i] = issue_en &&
                    (issue_dest == IDX) &&
                    !(HAS_ZERO && (i == ZERO_REG_IDX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumReg; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < NumReg; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wr_val[i];
        end
      end
      // A new producer outranks the writeback.
      busy <= set | (busy & ~wr_hit);
    end
  end

  assign busy_vec = busy;

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_rd
    logic                bp_hit;
    logic [BitWidth-1:0] bp_data;
    logic [BitWidth-1:0] st_val;
    logic                st_busy;
    logic [BitWidth-1:0] rd_val;
    logic                rd_bsy;

    regfile_wr_sel #(
      .BitWidth      (BitWidth),
      .NumReg        (NumReg),
      .NumWritePorts (NumWritePorts),
      .ZeroReg       (ZeroReg)
    ) u_byp (
      .write_en   (write_en),
      .write_dest (write_dest),
      .write_data (write_data),
      .addr       (read_src[r]),
      .hit        (bp_hit),
      .data       (bp_data)
    );

    // Out-of-range sources match no entry and read 0.
    always_comb begin
      st_val  = '0;
      st_busy = 1'b0;
      for (int i = 0; i < NumReg; i++) begin
        if (read_src[r] == AW'(i)) begin
          st_val  = regs[i];
          st_busy = busy[i];
        end
      end
    end

    always_comb begin
      rd_val = '0;
      rd_bsy = 1'b0;
      if (rst) begin
        rd_val = '0;
        rd_bsy = 1'b0;
      end else if (HAS_ZERO &&
                   (read_src[r] == ZIDX)) begin
        rd_val = '0;
        rd_bsy = 1'b0;
      end else if (HAS_BYP && bp_hit) begin
        rd_val = bp_data;
        rd_bsy = 1'b0;
      end else begin
        rd_val = st_val;
        rd_bsy = st_busy;
      end
    end

    assign read_data[r] = rd_val;
    assign read_busy[r] = rd_bsy;
  end

endmodule

// File: tb/tb_regfile_mpsb.sv
// Directed checks of regfile_mpsb in three
// configurations driven by a shared stimulus bus.
module tb_regfile_mpsb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0][4:0]  read_src;
  logic [1:0]       write_en;
  logic [1:0][4:0]  write_dest;
  logic [1:0][31:0] write_data;
  logic             issue_en;
  logic [4:0]       issue_dest;

  logic [1:0][31:0] rd_a, rd_b, rd_c;
  logic [1:0]       rb_a, rb_b, rb_c;
  logic [31:0]      bv_a, bv_b;
  logic [19:0]      bv_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mpsb u_a (
    .clk (clk), .rst (rst),
    .read_src (read_src), .read_data (rd_a),
    .read_busy (rb_a),
    .write_en (write_en), .write_dest (write_dest),
    .write_data (write_data),
    .issue_en (issue_en), .issue_dest (issue_dest),
    .busy_vec (bv_a)
  );

  regfile_mpsb #(.ZeroReg(0), .Bypass(0)) u_b (
    .clk (clk), .rst (rst),
    .read_src (read_src), .read_data (rd_b),
    .read_busy (rb_b),
    .write_en (write_en), .write_dest (write_dest),
    .write_data (write_data),
    .issue_en (issue_en), .issue_dest (issue_dest),
    .busy_vec (bv_b)
  );

  regfile_mpsb #(.NumReg(20)) u_c (
    .clk (clk), .rst (rst),
    .read_src (read_src), .read_data (rd_c),
    .read_busy (rb_c),
    .write_en (write_en), .write_dest (write_dest),
    .write_data (write_data),
    .issue_en (issue_en), .issue_dest (issue_dest),
    .busy_vec (bv_c)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  d0, d1;
    logic [31:0] w0, w1;
    logic        ie;
    logic [4:0]  id, rs0, rs1;
    logic [31:0] rd0;
    logic        rb0;
    logic [31:0] rd1;
    logic [31:0] bv;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we,
                       input logic [4:0] d0,
                       input logic [31:0] w0,
                       input logic [4:0] d1,
                       input logic [31:0] w1,
                       input logic ie,
                       input logic [4:0] id,
                       input logic [4:0] rs0,
                       input logic [4:0] rs1);
    write_en      = we;
    write_dest[0] = d0;
    write_data[0] = w0;
    write_dest[1] = d1;
    write_data[1] = w1;
    issue_en      = ie;
    issue_dest    = id;
    read_src[0]   = rs0;
    read_src[1]   = rs1;
  endtask

  task automatic idle(input logic [4:0] rs0,
                      input logic [4:0] rs1);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
          1'b0, 5'd0, rs0, rs1);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{2'b01, 5'd3, 5'd0, 32'h1234, 32'h0,
               1'b0, 5'd0, 5'd3, 5'd0,
               32'h1234, 1'b0, 32'h0, 32'h0};
    tv[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b1, 5'd9, 5'd3, 5'd9,
               32'h1234, 1'b0, 32'h0, 32'h200};
    tv[2]  = '{2'b01, 5'd9, 5'd0, 32'h99, 32'h0,
               1'b1, 5'd9, 5'd9, 5'd3,
               32'h99, 1'b0, 32'h1234, 32'h200};
    tv[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b0, 5'd0, 5'd9, 5'd3,
               32'h99, 1'b1, 32'h1234, 32'h200};
    tv[4]  = '{2'b10, 5'd0, 5'd9, 32'h0, 32'h77,
               1'b0, 5'd0, 5'd9, 5'd9,
               32'h77, 1'b0, 32'h77, 32'h0};
    tv[5]  = '{2'b11, 5'd7, 5'd7, 32'hAAAA_0001,
               32'hBBBB_0002, 1'b0, 5'd0, 5'd7, 5'd9,
               32'hBBBB_0002, 1'b0, 32'h77, 32'h0};
    tv[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b0, 5'd0, 5'd7, 5'd3,
               32'hBBBB_0002, 1'b0, 32'h1234, 32'h0};
    tv[7]  = '{2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0,
               1'b1, 5'd0, 5'd0, 5'd7,
               32'h0, 1'b0, 32'hBBBB_0002, 32'h0};
    tv[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b0, 5'd0, 5'd0, 5'd0,
               32'h0, 1'b0, 32'h0, 32'h0};
    tv[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b1, 5'd12, 5'd12, 5'd7,
               32'h0, 1'b0, 32'hBBBB_0002, 32'h1000};
    tv[10] = '{2'b01, 5'd12, 5'd0, 32'h5, 32'h0,
               1'b1, 5'd31, 5'd12, 5'd31,
               32'h5, 1'b0, 32'h0, 32'h8000_0000};
    tv[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b0, 5'd0, 5'd12, 5'd31,
               32'h5, 1'b0, 32'h0, 32'h8000_0000};
    tv[12] = '{2'b10, 5'd0, 5'd31, 32'h0, 32'h31,
               1'b1, 5'd31, 5'd31, 5'd12,
               32'h31, 1'b0, 32'h5, 32'h8000_0000};
    tv[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b0, 5'd0, 5'd31, 5'd12,
               32'h31, 1'b1, 32'h5, 32'h8000_0000};
    tv[14] = '{2'b01, 5'd31, 5'd0, 32'h32, 32'h0,
               1'b0, 5'd0, 5'd31, 5'd7,
               32'h32, 1'b0, 32'hBBBB_0002, 32'h0};
    tv[15] = '{2'b11, 5'd4, 5'd5, 32'h44, 32'h55,
               1'b0, 5'd0, 5'd4, 5'd5,
               32'h44, 1'b0, 32'h55, 32'h0};

    idle(5'd0, 5'd0);
    #1;
    chk("rst_rd0", rd_a[0], 32'h0);
    chk("rst_bv", bv_a, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tv[i].we, tv[i].d0, tv[i].w0,
            tv[i].d1, tv[i].w1, tv[i].ie,
            tv[i].id, tv[i].rs0, tv[i].rs1);
      #1;
      chk($sformatf("v%0d_rd0", i), rd_a[0], tv[i].rd0);
      chk($sformatf("v%0d_rb0", i),
          {31'h0, rb_a[0]}, {31'h0, tv[i].rb0});
      chk($sformatf("v%0d_rd1", i), rd_a[1], tv[i].rd1);
      edge1();
      chk($sformatf("v%0d_bv", i), bv_a, tv[i].bv);
      @(negedge clk);
    end

    idle(5'd0, 5'd0);
    #1;
    chk("nz_rd_x0", rd_b[0], 32'hFFFF_FFFF);
    chk("nz_rb_x0", {31'h0, rb_b[0]}, 32'h1);
    chk("nz_bv", bv_b, 32'h1);
    chk("n20_bv", {12'h0, bv_c}, 32'h0);

    @(negedge clk);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
          1'b1, 5'd3, 5'd3, 5'd0);
    edge1();
    chk("nb_bv_issue", bv_b, 32'h9);
    @(negedge clk);
    drive(2'b01, 5'd3, 32'hABCD, 5'd0, 32'h0,
          1'b0, 5'd0, 5'd3, 5'd0);
    #1;
    chk("nb_pre_rd", rd_b[0], 32'h1234);
    chk("nb_pre_rb", {31'h0, rb_b[0]}, 32'h1);
    chk("byp_pre_rd", rd_a[0], 32'hABCD);
    chk("byp_pre_rb", {31'h0, rb_a[0]}, 32'h0);
    edge1();
    chk("nb_post_rd", rd_b[0], 32'hABCD);
    chk("nb_post_bv", bv_b, 32'h1);

    @(negedge clk);
    drive(2'b01, 5'd25, 32'hDEAD, 5'd0, 32'h0,
          1'b1, 5'd25, 5'd25, 5'd25);
    #1;
    chk("n20_pre_rd", rd_c[0], 32'h0);
    chk("n20_pre_rb", {31'h0, rb_c[0]}, 32'h0);
    chk("n32_pre_rd25", rd_a[0], 32'hDEAD);
    edge1();
    chk("n20_post_rd", rd_c[0], 32'h0);
    chk("n20_post_bv", {12'h0, bv_c}, 32'h0);
    chk("n32_post_bv", bv_a, 32'h0200_0000);
    @(negedge clk);
    drive(2'b01, 5'd19, 32'h19, 5'd0, 32'h0,
          1'b0, 5'd0, 5'd19, 5'd25);
    #1;
    chk("n20_byp19", rd_c[0], 32'h19);
    edge1();
    chk("n20_rd19", rd_c[0], 32'h19);
    chk("n20_rd25", rd_c[1], 32'h0);

    @(negedge clk);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
          1'b1, 5'd7, 5'd7, 5'd5);
    edge1();
    chk("pre_rst_bv", bv_a, 32'h0200_0080);
    chk("pre_rst_rd7", rd_a[0], 32'hBBBB_0002);
    #3;
    drive(2'b01, 5'd7, 32'h5A5A, 5'd0, 32'h0,
          1'b1, 5'd6, 5'd7, 5'd5);
    rst = 1'b1;
    #1;
    chk("rst_mid_rd", rd_a[0], 32'h0);
    chk("rst_mid_rb", {31'h0, rb_a[0]}, 32'h0);
    chk("rst_mid_bv", bv_a, 32'h0);
    chk("rst_mid_rd_nb", rd_b[0], 32'h0);
    edge1();
    chk("rst_edge_bv", bv_a, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(5'd5, 5'd7);
    #1;
    chk("post_rst_x5", rd_a[0], 32'h0);
    chk("post_rst_x7", rd_a[1], 32'h0);
    chk("post_rst_bv", bv_a, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
